// File: rtl/trng_sequencer.sv
// Latch-ring TRNG sequencer: excite, settle, sample, repetition test, byte packing.
// Define TRNG_VN_DEBIAS_EN to enable von Neumann debiasing of raw samples.
module trng_sequencer #(
  parameter int EXCITE_LEN = 1,
  parameter int SETTLE     = 6,
  parameter int REP_LIMIT  = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       raw_bit,
  output logic       excite,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       health_fail,
  output logic       overrun,
  input  logic       clear_fail,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXCITE,
    ST_SETTLE,
    ST_SAMPLE
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] tmr_q, tmr_d;
  logic       sync1_q, sync2_q;
  logic       prev_q, prev_d;
  logic [7:0] run_q, run_d, run_nx;
  logic [6:0] shift_q, shift_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] out_q, out_d;
  logic       valid_q, valid_d;
  logic       hf_q, hf_d;
  logic       ovr_q, ovr_d;
  logic       excite_q, excite_d;
  logic       busy_q, busy_d;
  logic       acc, acc_bit, byte_done, load;
`ifdef TRNG_VN_DEBIAS_EN
  logic       pv_q, pv_d;
  logic       pb_q, pb_d;
`endif

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    prev_d    = prev_q;
    run_d     = clear_fail ? 8'd0 : run_q;
    run_nx    = 8'd0;
    shift_d   = shift_q;
    bcnt_d    = bcnt_q;
    hf_d      = hf_q & ~clear_fail;
    ovr_d     = ovr_q & ~clear_fail;
    acc       = 1'b0;
    acc_bit   = 1'b0;
    byte_done = 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
    pv_d      = pv_q & ~clear_fail;
    pb_d      = pb_q;
`endif
    if (!enable) begin
      state_d = ST_IDLE;
      bcnt_d  = 3'd0;
`ifdef TRNG_VN_DEBIAS_EN
      pv_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!hf_q || clear_fail) begin
            state_d = ST_EXCITE;
            tmr_d   = 6'(EXCITE_LEN - 1);
          end
        end
        ST_EXCITE: begin
          if (tmr_q == 6'd0) begin
            state_d = ST_SETTLE;
            tmr_d   = 6'(SETTLE - 1);
          end else begin
            tmr_d = tmr_q - 6'd1;
          end
        end
        ST_SETTLE: begin
          if (tmr_q == 6'd0) state_d = ST_SAMPLE;
          else tmr_d = tmr_q - 6'd1;
        end
        ST_SAMPLE: begin
          state_d = ST_EXCITE;
          tmr_d   = 6'(EXCITE_LEN - 1);
          prev_d  = sync2_q;
          if (run_d != 8'd0 && sync2_q == prev_q) run_nx = run_d + 8'd1;
          else run_nx = 8'd1;
          run_d = run_nx;
          // A tripping sample wins over a same-cycle clear_fail
          if (run_nx == 8'(REP_LIMIT)) begin
            hf_d    = 1'b1;
            state_d = ST_IDLE;
            bcnt_d  = 3'd0;
`ifdef TRNG_VN_DEBIAS_EN
            pv_d    = 1'b0;
`endif
          end else begin
`ifdef TRNG_VN_DEBIAS_EN
            if (!pv_d) begin
              pv_d = 1'b1;
              pb_d = sync2_q;
            end else begin
              pv_d    = 1'b0;
              acc     = (pb_q != sync2_q);
              acc_bit = pb_q;
            end
`else
            acc     = 1'b1;
            acc_bit = sync2_q;
`endif
          end
        end
      endcase
    end

    if (acc) begin
      if (bcnt_q == 3'd7) begin
        byte_done = 1'b1;
        bcnt_d    = 3'd0;
      end else begin
        shift_d = {shift_q[5:0], acc_bit};
        bcnt_d  = bcnt_q + 3'd1;
      end
    end

    load    = byte_done & (~valid_q | data_ready);
    out_d   = load ? {shift_q, acc_bit} : out_q;
    valid_d = load | (valid_q & ~data_ready);
    if (byte_done && !load) ovr_d = 1'b1;

    excite_d = (state_d != ST_EXCITE);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      tmr_q    <= 6'd0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      run_q    <= 8'd0;
      shift_q  <= 7'd0;
      bcnt_q   <= 3'd0;
      out_q    <= 8'd0;
      valid_q  <= 1'b0;
      hf_q     <= 1'b0;
      ovr_q    <= 1'b0;
      excite_q <= 1'b1;
      busy_q   <= 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
      pv_q     <= 1'b0;
      pb_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      sync1_q  <= raw_bit;
      sync2_q  <= sync1_q;
      prev_q   <= prev_d;
      run_q    <= run_d;
      shift_q  <= shift_d;
      bcnt_q   <= bcnt_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      hf_q     <= hf_d;
      ovr_q    <= ovr_d;
      excite_q <= excite_d;
      busy_q   <= busy_d;
`ifdef TRNG_VN_DEBIAS_EN
      pv_q     <= pv_d;
      pb_q     <= pb_d;
`endif
    end
  end

  assign excite      = excite_q;
  assign data_out    = out_q;
  assign data_valid  = valid_q;
  assign health_fail = hf_q;
  assign overrun     = ovr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_trng_sequencer.sv
// Self-checking bench for trng_sequencer against a per-sample reference model.
// Honours TRNG_VN_DEBIAS_EN the same way as the design build.
module tb_trng_sequencer;
  localparam int P   = 8;
  localparam int REP = 32;

  logic       clk = 1'b0;
  logic       resetn, enable, raw_bit, data_ready, clear_fail;
  logic       excite, data_valid, health_fail, overrun, busy;
  logic [7:0] data_out;
  int         n_cmp = 0;
  int         n_bad = 0;

  trng_sequencer #(
    .EXCITE_LEN(1),
    .SETTLE(6),
    .REP_LIMIT(REP)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .raw_bit(raw_bit),
    .excite(excite),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .health_fail(health_fail),
    .overrun(overrun),
    .clear_fail(clear_fail),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model, updated once per raw sample
  int         m_prev, m_run, m_pair;
  bit         m_hf, m_ovr, m_valid;
  logic [7:0] m_out;
  bit         acc[$];

  task automatic model_reset();
    m_prev = 0; m_run = 0; m_pair = -1;
    m_hf = 0; m_ovr = 0; m_valid = 0; m_out = 8'h00;
    acc.delete();
  endtask

  task automatic model_sample(bit s);
    logic [7:0] b;
    if (m_valid && data_ready) m_valid = 0;
    m_run = (m_run > 0 && int'(s) == m_prev) ? m_run + 1 : 1;
    m_prev = int'(s);
    if (m_run == REP) begin
      m_hf = 1; acc.delete(); m_pair = -1;
      return;
    end
`ifdef TRNG_VN_DEBIAS_EN
    if (m_pair < 0) m_pair = int'(s);
    else begin
      if (m_pair != int'(s)) acc.push_back(m_pair[0]);
      m_pair = -1;
    end
`else
    acc.push_back(s);
`endif
    if (acc.size() == 8) begin
      b = 8'h00;
      foreach (acc[i]) b = {b[6:0], acc[i]};
      acc.delete();
      if (!m_valid) begin m_out = b; m_valid = 1; end
      else m_ovr = 1;
    end
  endtask

  task automatic do_reset();
    resetn = 0; enable = 0; clear_fail = 0; raw_bit = 0; data_ready = 0;
    @(posedge clk); #1;
    resetn = 1;
    model_reset();
  endtask

  task automatic start();
    enable = 1;
    @(posedge clk); #1;
  endtask

  task automatic stop();
    enable = 0;
    @(posedge clk); #1;
    acc.delete(); m_pair = -1;
    if (m_valid && data_ready) m_valid = 0;
  endtask

  task automatic period(bit s);
    raw_bit = s;
    repeat (P) @(posedge clk);
    #1;
    model_sample(s);
  endtask

  task automatic test_reset();
    resetn = 0; enable = 0; clear_fail = 0; raw_bit = 0; data_ready = 0;
    #12;
    n_cmp++; if (excite !== 1'b1) begin n_bad++; $display("FAIL reset_excite: got %b want 1", excite); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL reset_hf: got %b want 0", health_fail); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    resetn = 1;
    model_reset();
  endtask

  task automatic test_alternate();
    do_reset();
    data_ready = 1;
    start();
    for (int i = 0; i < 8; i++) period(i % 2 == 0);
    n_cmp++; if (data_valid !== m_valid) begin n_bad++; $display("FAIL alt_valid: got %b want %b", data_valid, m_valid); end
    n_cmp++; if (data_out !== m_out) begin n_bad++; $display("FAIL alt_data: got %h want %h", data_out, m_out); end
`ifndef TRNG_VN_DEBIAS_EN
    n_cmp++; if (data_out !== 8'hAA) begin n_bad++; $display("FAIL alt_aa: got %h want aa", data_out); end
`endif
    n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL alt_hf: got %b want 0", health_fail); end
    stop();
  endtask

  task automatic test_health();
    do_reset();
    data_ready = 1;
    start();
    for (int i = 0; i < REP; i++) begin
      period(1'b1);
      if (i == REP - 2) begin
        n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL hf_early: got %b want 0", health_fail); end
      end
    end
    n_cmp++; if (health_fail !== m_hf) begin n_bad++; $display("FAIL hf_trip: got %b want %b", health_fail, m_hf); end
    n_cmp++; if (data_valid !== m_valid) begin n_bad++; $display("FAIL hf_valid: got %b want %b", data_valid, m_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hf_busy: got %b want 0", busy); end
    repeat (5) @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hf_stays_idle: got %b want 0", busy); end
    clear_fail = 1;
    @(posedge clk); #1;
    clear_fail = 0;
    m_hf = 0; m_ovr = 0; m_run = 0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hf_resume: got %b want 1", busy); end
    n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL hf_clear: got %b want 0", health_fail); end
    for (int i = 0; i < 8; i++) period(1'($urandom));
    n_cmp++; if (data_out !== m_out) begin n_bad++; $display("FAIL hf_after_data: got %h want %h", data_out, m_out); end
    stop();
  endtask

  task automatic test_overrun();
    logic [7:0] first;
    do_reset();
    data_ready = 0;
    start();
    for (int i = 0; i < 8; i++) period(i % 3 == 0);
    first = m_out;
    n_cmp++; if (data_valid !== m_valid) begin n_bad++; $display("FAIL ovr_valid1: got %b want %b", data_valid, m_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_early: got %b want 0", overrun); end
    for (int i = 0; i < 8; i++) period(1'($urandom));
    n_cmp++; if (overrun !== m_ovr) begin n_bad++; $display("FAIL ovr_set: got %b want %b", overrun, m_ovr); end
    n_cmp++; if (data_out !== first) begin n_bad++; $display("FAIL ovr_hold: got %h want %h", data_out, first); end
    data_ready = 1;
    @(posedge clk); #1;
    m_valid = 0;
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_accept: got %b want 0", data_valid); end
    stop();
  endtask

  task automatic test_enable_drop();
    logic [7:0] drv;
    bit         s;
    do_reset();
    data_ready = 1;
    start();
    for (int i = 0; i < 5; i++) period(1'($urandom));
    n_cmp++; if (excite !== 1'b0) begin n_bad++; $display("FAIL drop_excite_lo: got %b want 0", excite); end
    stop();
    n_cmp++; if (excite !== 1'b1) begin n_bad++; $display("FAIL drop_excite_hi: got %b want 1", excite); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_busy: got %b want 0", busy); end
    start();
    drv = 8'h00;
    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom);
      drv = {drv[6:0], s};
      period(s);
    end
    n_cmp++; if (data_valid !== m_valid) begin n_bad++; $display("FAIL drop_valid: got %b want %b", data_valid, m_valid); end
    n_cmp++; if (data_out !== m_out) begin n_bad++; $display("FAIL drop_data: got %h want %h", data_out, m_out); end
`ifndef TRNG_VN_DEBIAS_EN
    n_cmp++; if (data_out !== drv) begin n_bad++; $display("FAIL drop_fresh: got %h want %h", data_out, drv); end
`endif
    stop();
  endtask

  task automatic test_vn_pattern();
    logic [7:0] pat;
    do_reset();
    data_ready = 1;
    pat = 8'b0110_0011;
    start();
    for (int i = 0; i < 32; i++) period(pat[7 - (i % 8)]);
    n_cmp++; if (data_valid !== m_valid) begin n_bad++; $display("FAIL vn_valid: got %b want %b", data_valid, m_valid); end
    n_cmp++; if (data_out !== m_out) begin n_bad++; $display("FAIL vn_data: got %h want %h", data_out, m_out); end
`ifdef TRNG_VN_DEBIAS_EN
    n_cmp++; if (data_out !== 8'h55) begin n_bad++; $display("FAIL vn_55: got %h want 55", data_out); end
`endif
    stop();
  endtask

  task automatic test_random();
    bit s;
    do_reset();
    s = 0;
    start();
    for (int i = 0; i < 200; i++) begin
      data_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) == 0) s = ~s;
      period(s);
      n_cmp++; if (data_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, data_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (data_out !== m_out) begin n_bad++; $display("FAIL rnd_data[%0d]: got %h want %h", i, data_out, m_out); end
      end
      n_cmp++; if (overrun !== m_ovr) begin n_bad++; $display("FAIL rnd_ovr[%0d]: got %b want %b", i, overrun, m_ovr); end
      n_cmp++; if (health_fail !== m_hf) begin n_bad++; $display("FAIL rnd_hf[%0d]: got %b want %b", i, health_fail, m_hf); end
      if (m_hf) break;
    end
    stop();
  endtask

  task automatic test_async_reset();
    do_reset();
    data_ready = 0;
    start();
    for (int i = 0; i < 8; i++) period(1'($urandom));
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL ar_pre_valid: got %b want 1", data_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ar_pre_busy: got %b want 1", busy); end
    resetn = 0;
    #1;
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid: got %b want 0", data_valid); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL ar_data: got %h want 00", data_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ar_busy: got %b want 0", busy); end
    n_cmp++; if (excite !== 1'b1) begin n_bad++; $display("FAIL ar_excite: got %b want 1", excite); end
    n_cmp++; if (health_fail !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("FAIL ar_flags: got %b%b want 00", health_fail, overrun); end
    enable = 0;
    @(posedge clk); #1;
    resetn = 1;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_health();
    test_overrun();
    test_enable_drop();
    test_vn_pattern();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trng_sequencer.md
# trng_sequencer

Controller for the latch-ring entropy source. Drives the source's excitation pulse and waits a programmable settle time. Samples the raw output bit and screens it with a repetition-count health test. Packs the accepted bits into bytes and hands them to a consumer over a valid/ready handshake. It sits between the ring primitive and the bus-side register or FIFO that reads random bytes.

## Interface
Parameters:
- EXCITE_LEN, 1: cycles `excite` is held low per sample (1–15).
- SETTLE, 6: cycles waited after excitation before sampling (2–63; must be ≥2 to cover the synchronizer).
- REP_LIMIT, 32: consecutive identical raw samples that trip the health test (2–255).

Ports:
- clk  in  1  sole clock.
- resetn  in  1  reset, asynchronous and active-low.
- enable  in  1  run sequencer while high.
- raw_bit  in  1  asynchronous output of the entropy source.
- excite  out  1  active-low excitation pulse to the source; idle high.
- data_out  out  8  random byte.
- data_valid  out  1  data_out holds an unconsumed byte.
- data_ready  in  1  consumer accepts byte when high with data_valid.
- health_fail  out  1  sticky repetition-test failure.
- overrun  out  1  sticky: a completed byte was dropped.
- clear_fail  in  1  one-cycle pulse; clears health_fail, overrun and the run counter.
- busy  out  1  FSM not in IDLE.

## Operation
- raw_bit passes through a 2-flop synchronizer. Only the synchronized value is used.
- FSM states and transitions:
  - IDLE: entered on reset. Goes to EXCITE when enable=1 and health_fail=0.
  - EXCITE: excite=0 for EXCITE_LEN cycles, then SETTLE.
  - SETTLE: SETTLE cycles, then SAMPLE.
  - SAMPLE: one cycle; the synchronized bit is taken. Goes to EXCITE if enable=1, else IDLE.
- enable=0 in any state: IDLE at the next edge, excite returns to 1, partial byte discarded (bit count cleared). The output register is untouched.
- Health test on every raw sample:
  - Run counter increments when the sample equals the previous sample; otherwise it resets to 1.
  - When the counter reaches REP_LIMIT, health_fail sets, the partial byte is discarded and the FSM goes to IDLE.
  - The FSM stays in IDLE until clear_fail.
  - The failing sample is never accepted into a byte.
- Byte assembly:
  - Accepted bits shift in left; the first accepted bit ends up in data_out[7].
  - A 3-bit count wraps from 7 to 0 when the byte completes.
- Output register (one entry):
  - A completed byte loads it if data_valid=0, or if data_valid&data_ready holds in the same cycle (accept-and-reload, no bubble).
  - Otherwise the byte is dropped and overrun sets.
  - data_valid clears on data_valid&data_ready unless a reload happens in that cycle.
- clear_fail and a failing sample in the same cycle: the failure wins and health_fail stays set.

## Timing
- Reset values: excite=1, data_out=0, data_valid=0, health_fail=0, overrun=0, busy=0. Bit count and run counter are 0.
- Sample period P = EXCITE_LEN+SETTLE+1 cycles. Defaults give P=8.
- The first EXCITE cycle follows the edge on which enable is seen high.
- data_valid rises the cycle after the SAMPLE that completes a byte.
- Minimum byte latency without debiasing is 8·P cycles; with defaults, 64 cycles from enable.
- data_out is stable while data_valid=1 and data_ready=0.
- health_fail and overrun are registered and assert the cycle after their cause.

## Configuration
- TRNG_VN_DEBIAS_EN defined: raw samples are paired (first, second) for von Neumann debiasing.
  - 01 yields 0; 10 yields 1; 00 and 11 yield nothing.
  - The pair register clears on enable=0, health failure and clear_fail.
  - The health test still runs on every raw sample.
- Undefined: every raw sample that passes the health test is accepted directly.

## Test plan
- Alternate raw_bit 1,0,1,0… with defaults and the macro undefined; ready held 1 → after 64 cycles data_valid=1 with data_out=8'hAA. No health_fail.
- raw_bit stuck at 1 with REP_LIMIT=32 → health_fail=1 on the 32nd sample, no data_valid, busy=0. clear_fail pulse → sequencing resumes on the next edge.
- data_ready held 0 across two completed bytes → first byte held stable, overrun=1 after the second completes. Then raise ready → first byte accepted and data_valid=0.
- enable dropped after 5 accepted bits, then raised → excite=1 the next cycle, and the next byte contains only bits sampled after re-enable.
- TRNG_VN_DEBIAS_EN defined, raw sequence 0,1,1,0,0,0,1,1 repeated → only 01→0 and 10→1 accepted. Byte = 8'h55 after 32 raw samples.
- Assert resetn low mid-SETTLE with data_valid=1 → all outputs return to their reset values asynchronously.
